// File: rtl/conv2d_stream_engine.sv
// conv2d_stream_engine: streaming 3x3 convolution over one raster frame with a programmable kernel,
// selectable arithmetic shift and ReLU, valid/ready on both sides.
module conv2d_stream_engine #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  localparam int ACC_W = DATA_W + COEF_W + 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cfg_relu,
  input  logic [3:0]        cfg_shift,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [COEF_W-1:0] wr_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              busy,
  output logic              done
);
  localparam int P_W = DATA_W + COEF_W + 1;
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DONE = 2'd3;

  logic [1:0] state;
  logic [XW-1:0] cnt_x;
  logic [YW-1:0] cnt_y;
  logic relu_q;
  logic [3:0] shift_q;
  logic signed [COEF_W-1:0] coef [9];
  logic [DATA_W-1:0] lb_a [IMG_W];
  logic [DATA_W-1:0] lb_b [IMG_W];
  logic [DATA_W-1:0] win [9];
  logic signed [P_W-1:0] prod [9];
  logic v1, v2, en, accept, last_px;
  logic signed [ACC_W-1:0] sum, res;

  assign en = !(out_valid && !out_ready);
  assign in_ready = state == RUN && en;
  assign accept = in_valid && in_ready;
  assign last_px = cnt_x == X_MAX && cnt_y == Y_MAX;
  assign busy = state != IDLE;
  assign done = state == DONE;

  always_comb begin
    sum = '0;
    for (int i = 0; i < 9; i++) sum = sum + ACC_W'(prod[i]);
    res = sum >>> shift_q;
    res = (relu_q && res[ACC_W-1]) ? '0 : res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt_x <= '0;
      cnt_y <= '0;
      relu_q <= 1'b0;
      shift_q <= '0;
      coef <= '{COEF_W'(1), '0, COEF_W'(-1), COEF_W'(2), '0, COEF_W'(-2), COEF_W'(1), '0, COEF_W'(-1)};
    end else begin
      if (state == IDLE && wr_en && wr_addr <= 4'd8) coef[wr_addr] <= wr_data;
      if (state == IDLE && start) begin
        state <= RUN;
        relu_q <= cfg_relu;
        shift_q <= cfg_shift;
        cnt_x <= '0;
        cnt_y <= '0;
      end
      if (accept) begin
        cnt_x <= cnt_x == X_MAX ? '0 : cnt_x + 1'b1;
        cnt_y <= cnt_x == X_MAX ? cnt_y + 1'b1 : cnt_y;
        if (last_px) state <= FLUSH;
      end
      // Leave FLUSH only once the final result has been taken and nothing is still in the pipe
      if (state == FLUSH && out_valid && out_ready && !v1 && !v2) state <= DONE;
      if (state == DONE) state <= IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb_b[cnt_x] <= lb_a[cnt_x];
      lb_a[cnt_x] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      win <= '{default: '0};
      prod <= '{default: '0};
    end else if (en) begin
      v1 <= accept && cnt_x >= XW'(2) && cnt_y >= YW'(2);
      if (accept) begin
        win[0] <= win[1];
        win[1] <= win[2];
        win[2] <= lb_b[cnt_x];
        win[3] <= win[4];
        win[4] <= win[5];
        win[5] <= lb_a[cnt_x];
        win[6] <= win[7];
        win[7] <= win[8];
        win[8] <= in_data;
      end
      for (int i = 0; i < 9; i++) prod[i] <= P_W'($signed({1'b0, win[i]})) * P_W'(coef[i]);
      v2 <= v1;
      out_valid <= v2;
      out_data <= res;
    end
  end
endmodule

// File: tb/tb_conv2d_stream_engine.sv
// tb_conv2d_stream_engine: directed frames against a golden 3x3 convolution model with a result scoreboard,
// covering stalls, input gaps, kernel programming, shift/ReLU and mid-frame reset.
module tb_conv2d_stream_engine;
  localparam int IMG_W = 32;
  localparam int IMG_H = 32;
  localparam int ACC_W = 21;
  localparam int N_PIX = IMG_W * IMG_H;
  localparam int N_RES = (IMG_W - 2) * (IMG_H - 2);

  logic clk = 1'b0;
  logic rst, start, cfg_relu, wr_en, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [3:0] cfg_shift, wr_addr;
  logic [7:0] wr_data, in_data;
  logic [ACC_W-1:0] out_data;

  int errs = 0;
  int checks = 0;
  int img [IMG_H][IMG_W];
  int km [9];
  int exp_q [$];
  int cyc_q [$];

  conv2d_stream_engine dut (
    .clk(clk), .rst(rst), .start(start), .cfg_relu(cfg_relu), .cfg_shift(cfg_shift),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int expv);
    checks++;
    assert (got === expv) else begin
      errs++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, expv);
    end
  endtask

  function automatic int model(input int x, input int y, input bit relu, input int shift);
    int s = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) s += img[y - 2 + r][x - 2 + c] * km[r * 3 + c];
    s = s >>> shift;
    if (relu && s < 0) s = 0;
    return s;
  endfunction

  task automatic set_sobel();
    km = '{1, 0, -1, 2, 0, -2, 1, 0, -1};
  endtask

  task automatic fill(input int mode);
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++)
        img[y][x] = mode == 0 ? 10 : mode == 1 ? x : mode == 2 ? (y * IMG_W + x) % 256 :
                    mode == 3 ? int'($urandom_range(0, 255)) : 255;
  endtask

  task automatic wr_coef(input int a, input int d);
    wr_en = 1'b1;
    wr_addr = 4'(a);
    wr_data = 8'(d);
    @(negedge clk);
    wr_en = 1'b0;
    if (a < 9) km[a] = d;
  endtask

  task automatic run_frame(input bit relu, input int shift, input bit gaps, input bit stalls,
                           input bit lat, input int abort_row, input bit wr_run);
    int p, nres, ndone, post, x, y, c;
    bit stalled;
    logic [ACC_W-1:0] held;
    logic signed [ACC_W-1:0] got;
    p = 0; nres = 0; ndone = 0; post = -1; stalled = 0; held = '0;
    exp_q.delete();
    cyc_q.delete();
    start = 1'b1; cfg_relu = relu; cfg_shift = 4'(shift); out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int it = 0; it < 20000; it++) begin
      if (abort_row >= 0 && p == abort_row * IMG_W) begin
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        repeat (6) begin
          @(negedge clk);
          #1;
          ndone += int'(done);
        end
        chk("abort_no_done", ndone, 0);
        set_sobel();
        return;
      end
      in_valid = p < N_PIX && (!gaps || $urandom_range(0, 3) != 0);
      in_data = p < N_PIX ? 8'(img[p / IMG_W][p % IMG_W]) : 8'd0;
      out_ready = !stalls || $urandom_range(0, 2) != 0;
      wr_en = wr_run && p == 40;
      wr_addr = 4'd4;
      wr_data = 8'd99;
      #1;
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_hold", int'(out_data), int'(held));
      end
      stalled = out_valid && !out_ready;
      held = out_data;
      if (in_valid && in_ready) begin
        x = p % IMG_W;
        y = p / IMG_W;
        if (x >= 2 && y >= 2) begin
          exp_q.push_back(model(x, y, relu, shift));
          cyc_q.push_back(it);
        end
        p++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_result", 1, 0);
        else begin
          got = out_data;
          chk("result", int'(got), exp_q.pop_front());
          c = cyc_q.pop_front();
          if (lat) chk("latency", it - c, 3);
        end
        nres++;
      end
      if (done) ndone++;
      if (post >= 0) post++;
      else if (done) post = 0;
      @(negedge clk);
      if (post == 3) break;
    end
    wr_en = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b0;
    chk("frame_complete", int'(post == 3), 1);
    chk("result_count", nres, N_RES);
    chk("done_pulses", ndone, 1);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_relu = 1'b0; cfg_shift = 4'd0;
    wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'd0;
    in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b1;
    set_sobel();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_done", done, 0);
    chk("reset_busy", busy, 0);
    @(negedge clk);

    fill(0);
    run_frame(0, 0, 0, 0, 1, -1, 0);
    fill(1);
    run_frame(0, 0, 0, 0, 1, -1, 0);
    run_frame(0, 1, 0, 0, 1, -1, 0);
    run_frame(1, 0, 0, 0, 1, -1, 0);

    for (int a = 0; a < 9; a++) wr_coef(a, a == 4 ? 1 : 0);
    wr_coef(15, 77);
    fill(2);
    run_frame(0, 0, 0, 0, 1, -1, 0);

    for (int a = 0; a < 9; a++) wr_coef(a, int'($urandom_range(0, 255)) - 128);
    fill(3);
    run_frame(0, 2, 1, 1, 0, -1, 0);
    fill(3);
    run_frame(1, 0, 1, 1, 0, -1, 0);

    for (int a = 0; a < 9; a++) wr_coef(a, -128);
    fill(4);
    run_frame(0, 0, 0, 0, 1, -1, 1);
    chk("min_weight_value", model(5, 5, 0, 0), -293760);

    fill(3);
    run_frame(0, 0, 0, 0, 0, 15, 0);
    fill(3);
    run_frame(0, 0, 1, 1, 0, -1, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/conv2d_stream_engine.md
Name: conv2d_stream_engine

Overview:
- Parametrised 3x3 streaming 2D convolution engine, the next generation of the fixed Sobel engine.
- Accepts one raster-scan frame of unsigned pixels through a valid/ready input and emits one signed result per fully-valid window (no padding), (IMG_W-2)*(IMG_H-2) per frame, through a valid/ready output with backpressure.
- Kernel weights are programmable. ReLU and arithmetic right-shift are selectable per frame.
- Sits between the pixel source/DMA and the pooling/activation stage of the NPU datapath.

Parameters:
- DATA_W, 8, pixel width (unsigned).
- COEF_W, 8, kernel coefficient width (signed two's complement).
- IMG_W, 32, frame width in pixels, >=3.
- IMG_H, 32, frame height in pixels, >=3.
- ACC_W, DATA_W+COEF_W+5, result width (signed). Derived; must not be overridden.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  begin a frame (honoured in IDLE only)
- cfg_relu  in  1  clamp negative results to 0; sampled on start
- cfg_shift  in  4  arithmetic right-shift applied to the sum; sampled on start
- wr_en  in  1  kernel coefficient write strobe
- wr_addr  in  4  coefficient index 0..8, row-major; 0 = oldest row, oldest column
- wr_data  in  COEF_W  coefficient value
- in_valid  in  1  pixel valid
- in_ready  out  1  engine accepts the pixel this cycle
- in_data  in  DATA_W  pixel
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  ACC_W  signed result
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset:
  - state=IDLE; in_ready=0, out_valid=0, out_data=0, done=0, busy=0.
  - Pipeline registers and counters are cleared.
  - Kernel is reset to Sobel-x {1,0,-1,2,0,-2,1,0,-1}.
  - Line buffers are not cleared; they are never read before they are written in a frame.
- Kernel writes:
  - Take effect only in IDLE.
  - wr_en in any other state, or wr_addr>8, is ignored.
- FSM IDLE -> RUN -> FLUSH -> DONE -> IDLE:
  - IDLE: start -> RUN. cfg_relu/cfg_shift are latched and cnt_x/cnt_y cleared.
  - RUN: pixels are accepted. Acceptance of pixel (IMG_W-1, IMG_H-1) -> FLUSH.
  - FLUSH: in_ready=0. When the last result handshakes (out_valid&&out_ready) and no results remain in flight -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
  - start outside IDLE is ignored.
- Handshake:
  - en = !(out_valid && !out_ready); the whole pipeline advances only when en=1.
  - in_ready = (state==RUN) && en.
  - A pixel is accepted on in_valid && in_ready.
  - out_data is held stable while out_valid && !out_ready.
- Windowing:
  - Two line buffers of depth IMG_W plus a 3x3 window shift register, advanced per accepted pixel.
  - cnt_x wraps at IMG_W-1 and increments cnt_y.
  - A window is valid when the accepted pixel has cnt_x>=2 && cnt_y>=2.
  - Windows straddling a row wrap are never output.
- Pipeline:
  - 3 stages: window register -> 9 registered products -> adder tree + shift + ReLU into the output register.
  - Latency is exactly 3 enabled cycles from acceptance to out_valid. With no stall, a result appears 3 clocks after its pixel.
- Arithmetic:
  - Each product is zero-extended pixel x signed coef, DATA_W+COEF_W+1 bits.
  - The sum is sign-extended to ACC_W. ACC_W cannot overflow.
  - Result = sum >>> cfg_shift; if cfg_relu and result<0, result = 0.
- Throughput: one result per cycle sustained when in_valid=1 and out_ready=1.
- Reset mid-frame: returns to IDLE next cycle. In-flight results are discarded and no done pulse is issued.

Test Plan:
- Constant image, all pixels 10, default Sobel-x, out_ready=1 -> exactly 900 results, all 0; done pulses once; latency 3 cycles.
- Horizontal ramp pixel=x, shift=0, relu=0 -> every result -8. With shift=1 -> -4. With relu=1 -> 0.
- Load identity kernel (addr4=1, others 0), pixel=(y*IMG_W+x) mod 256 -> each result equals the centre pixel (x-1, y-1), in raster order.
- Random pixels, out_ready toggled pseudo-randomly and in_valid gapped -> the 900 results match the golden model. out_data is stable during stalls and none are lost or duplicated.
- All pixels 255, all weights -128 -> every result -293760, no wrap. wr_en asserted during RUN -> kernel unchanged.
- rst asserted at row 15 -> out_valid=0 next cycle and no done pulse. A subsequent start and full frame -> correct 900 results.
